// File: rtl/confreg_input_pkg.sv
// Shared peripheral address map and register-select decode for the board-input register block.
package confreg_input_pkg;

  localparam logic [15:0] SW_ADDR    = 16'hf010;
  localparam logic [15:0] BTN_ADDR   = 16'hf020;
  localparam logic [15:0] EVT_ADDR   = 16'hf024;
  localparam logic [15:0] IMASK_ADDR = 16'hf028;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_SW    = 3'd1,
    SEL_BTN   = 3'd2,
    SEL_EVT   = 3'd3,
    SEL_IMASK = 3'd4
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    reg_sel_e sel;
    case (addr)
      SW_ADDR:    sel = SEL_SW;
      BTN_ADDR:   sel = SEL_BTN;
      EVT_ADDR:   sel = SEL_EVT;
      IMASK_ADDR: sel = SEL_IMASK;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/confreg_input_if.sv
// conf_* peripheral bus: the CPU bridge is the master, register blocks are slaves.
interface confreg_input_if;

  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;

  modport master (
    output conf_en, conf_wen, conf_addr, conf_wdata,
    input  conf_rdata
  );

  modport slave (
    input  conf_en, conf_wen, conf_addr, conf_wdata,
    output conf_rdata
  );

endinterface

// File: rtl/confreg_input_sync_db.sv
// Two-flop synchronizer followed by a tick-sampled debouncer: a level is accepted
// into db only after it has been sampled identically on two consecutive ticks.
module input_sync_db #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_tick,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_db
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_samp;
  logic [W-1:0] r_db;
  logic [W-1:0] w_agree;
  logic [W-1:0] w_db_nxt;

  // Bits whose new sample matches the previous one take the new level; the rest hold.
  always_comb begin
    w_agree  = ~(r_s2 ^ r_samp);
    w_db_nxt = (w_agree & r_s2) | (~w_agree & r_db);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_samp <= '0;
      r_db   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (i_tick) begin
        r_samp <= r_s2;
        r_db   <= w_db_nxt;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/confreg_input.sv
// Memory-mapped switch/button input register with debounce, sticky W1C press
// events and a masked level interrupt.
module confreg_input
  import confreg_input_pkg::*;
#(
  parameter int NSW       = 16,
  parameter int NBTN      = 5,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  confreg_input_if.slave    conf,
  input  logic [NSW-1:0]    switch,
  input  logic [NBTN-1:0]   btn,
  output logic              btn_irq
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [CW-1:0]   r_cnt;
  logic            w_tick;
  logic [NSW-1:0]  w_db_sw;
  logic [NBTN-1:0] w_db_btn;
  logic [NBTN-1:0] r_btn_prev;
  logic [NBTN-1:0] r_arm;
  logic [1:0]      r_warm;
  logic [NBTN-1:0] r_evt;
  logic [NBTN-1:0] r_imask;
  logic [31:0]     r_rdata;

  reg_sel_e        w_sel;
  logic            w_wr;
  logic            w_rd;
  logic [NBTN-1:0] w_evt_set;
  logic [NBTN-1:0] w_evt_clr;
  logic [NBTN-1:0] w_evt_nxt;
  logic [31:0]     w_sw_ext;
  logic [31:0]     w_btn_ext;
  logic [31:0]     w_evt_ext;
  logic [31:0]     w_imask_ext;
  logic [31:0]     w_rd_mux;
  logic            w_unused;

  assign w_tick = (r_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  input_sync_db #(.W(NSW)) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .i_tick (w_tick),
    .i_raw  (switch),
    .o_db   (w_db_sw)
  );

  input_sync_db #(.W(NBTN)) u_btn_db (
    .clk    (clk),
    .reset  (reset),
    .i_tick (w_tick),
    .i_raw  (btn),
    .o_db   (w_db_btn)
  );

  // db only reflects two genuine post-reset samples from the fourth tick on, so a
  // button becomes armed for events once it has been seen released at that point.
  // This keeps a button held through reset from reporting a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm     <= 2'd0;
      r_arm      <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_prev <= w_db_btn;
      if (w_tick && (r_warm != 2'd3)) begin
        r_warm <= r_warm + 2'd1;
      end
      if (w_tick && (r_warm == 2'd3)) begin
        r_arm <= r_arm | ~w_db_btn;
      end
    end
  end

  always_comb begin
    w_sel     = decode_addr(conf.conf_addr[15:0]);
    w_wr      = conf.conf_en & (|conf.conf_wen);
    w_rd      = conf.conf_en & ~(|conf.conf_wen);
    w_evt_set = w_db_btn & ~r_btn_prev & r_arm;
    if (w_wr && (w_sel == SEL_EVT) && conf.conf_wen[0]) begin
      w_evt_clr = conf.conf_wdata[NBTN-1:0];
    end else begin
      w_evt_clr = '0;
    end
    // Set is OR-ed in after the clear so a same-cycle press survives the W1C.
    w_evt_nxt = w_evt_set | (r_evt & ~w_evt_clr);
  end

  always_comb begin
    w_sw_ext              = 32'd0;
    w_sw_ext[NSW-1:0]     = w_db_sw;
    w_btn_ext             = 32'd0;
    w_btn_ext[NBTN-1:0]   = w_db_btn;
    w_evt_ext             = 32'd0;
    w_evt_ext[NBTN-1:0]   = r_evt;
    w_imask_ext           = 32'd0;
    w_imask_ext[NBTN-1:0] = r_imask;
    case (w_sel)
      SEL_SW:    w_rd_mux = w_sw_ext;
      SEL_BTN:   w_rd_mux = w_btn_ext;
      SEL_EVT:   w_rd_mux = w_evt_ext;
      SEL_IMASK: w_rd_mux = w_imask_ext;
      default:   w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt   <= '0;
      r_imask <= '0;
      r_rdata <= 32'd0;
    end else begin
      r_evt <= w_evt_nxt;
      if (w_wr && (w_sel == SEL_IMASK)) begin
        r_imask <= conf.conf_wdata[NBTN-1:0];
      end
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign conf.conf_rdata = r_rdata;
  assign btn_irq         = |(r_evt & r_imask);

  assign w_unused = &{1'b0, conf.conf_addr[31:16], conf.conf_wdata};

endmodule

// File: tb/tb_confreg_input.sv
// Directed-vector bench for confreg_input with DB_CYCLES=4; every expected value is hand-computed.
module tb_confreg_input;

  localparam logic [15:0] A_SW    = 16'hf010;
  localparam logic [15:0] A_BTN   = 16'hf020;
  localparam logic [15:0] A_EVT   = 16'hf024;
  localparam logic [15:0] A_IMASK = 16'hf028;
  localparam logic [15:0] A_HOLE  = 16'hf0fc;

  logic        clk;
  logic        reset;
  logic [15:0] switch;
  logic [4:0]  btn;
  logic        btn_irq;
  int          n_vec;
  int          n_err;
  int          cyc;
  logic [31:0] rd;
  int          hits;
  logic        bad;

  confreg_input_if u_if ();

  confreg_input #(
    .NSW       (16),
    .NBTN      (5),
    .DB_CYCLES (4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .conf    (u_if.slave),
    .switch  (switch),
    .btn     (btn),
    .btn_irq (btn_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks into the edges where cyc % 4 == 0.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    u_if.conf_en   = 1'b1;
    u_if.conf_wen  = 4'h0;
    u_if.conf_addr = {16'h0000, a};
    @(negedge clk);
    d            = u_if.conf_rdata;
    u_if.conf_en = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] data, input logic [3:0] wen);
    u_if.conf_en    = 1'b1;
    u_if.conf_wen   = wen;
    u_if.conf_addr  = {16'h0000, a};
    u_if.conf_wdata = data;
    @(negedge clk);
    u_if.conf_en  = 1'b0;
    u_if.conf_wen = 4'h0;
  endtask

  // Back-to-back reads; hits = index of first read returning exp, bad = any value other than old/exp.
  task automatic poll_reg(input logic [15:0] a, input logic [31:0] exp, input logic [31:0] old,
                          input int budget, output int h, output logic b);
    logic [31:0] d;
    h = 0;
    b = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_read(a, d);
      if ((d !== exp) && (d !== old)) b = 1'b1;
      if ((d === exp) && (h == 0)) h = i + 1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    switch = 16'hffff;
    btn = 5'h00;
    u_if.conf_en = 1'b0;
    u_if.conf_wen = 4'h0;
    u_if.conf_addr = 32'h0;
    u_if.conf_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset with switches high, then they appear once debounced
    bus_read(A_SW, rd);   check_vec("t1_sw_after_reset", rd, 32'h0);
    bus_read(A_EVT, rd);  check_vec("t1_evt_after_reset", rd, 32'h0);
    check_vec("t1_irq_after_reset", {31'd0, btn_irq}, 32'h0);
    poll_reg(A_SW, 32'h0000ffff, 32'h0, 9, hits, bad);
    check_vec("t1_sw_within_11", {31'd0, hits != 0}, 32'h1);
    check_vec("t1_sw_no_partial", {31'd0, bad}, 32'h0);

    // 2: new stable switch pattern
    switch = 16'hA5A5;
    poll_reg(A_SW, 32'h0000a5a5, 32'h0000ffff, 12, hits, bad);
    check_vec("t2_sw_a5a5_seen", {31'd0, hits != 0}, 32'h1);
    check_vec("t2_sw_no_partial", {31'd0, bad}, 32'h0);
    bus_read(A_SW, rd);   check_vec("t2_sw_stable", rd, 32'h0000a5a5);

    // 3: glitches shorter than the debounce period are filtered
    btn[0] = 1'b1; @(negedge clk); btn[0] = 1'b0;
    repeat (5) @(negedge clk);
    btn[0] = 1'b1; repeat (3) @(negedge clk); btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    bus_read(A_BTN, rd);  check_vec("t3_btn_filtered", rd, 32'h0);
    bus_read(A_EVT, rd);  check_vec("t3_evt_filtered", rd, 32'h0);

    // 4: masked press raises irq; W1C clears; re-press sets again
    bus_write(A_IMASK, 32'h4, 4'hf);
    bus_read(A_IMASK, rd); check_vec("t4_imask_rd", rd, 32'h4);
    btn[2] = 1'b1; repeat (20) @(negedge clk);
    bus_read(A_BTN, rd);  check_vec("t4_btn_held", rd, 32'h4);
    bus_read(A_EVT, rd);  check_vec("t4_evt_set", rd, 32'h4);
    check_vec("t4_irq_set", {31'd0, btn_irq}, 32'h1);
    btn[2] = 1'b0; repeat (14) @(negedge clk);
    check_vec("t4_irq_sticky", {31'd0, btn_irq}, 32'h1);
    bus_write(A_EVT, 32'h4, 4'h1);
    check_vec("t4_irq_cleared", {31'd0, btn_irq}, 32'h0);
    bus_read(A_EVT, rd);  check_vec("t4_evt_cleared", rd, 32'h0);
    btn[2] = 1'b1; repeat (20) @(negedge clk);
    bus_read(A_EVT, rd);  check_vec("t4_evt_reset_again", rd, 32'h4);
    check_vec("t4_irq_again", {31'd0, btn_irq}, 32'h1);
    btn[2] = 1'b0; repeat (14) @(negedge clk);
    bus_write(A_EVT, 32'hffffffff, 4'h1);
    bus_read(A_EVT, rd);  check_vec("t4_evt_all_cleared", rd, 32'h0);

    // 5: W1C of bit 1 lands in the cycle its debounced rising edge is seen
    while ((cyc % 4) != 0) @(negedge clk);
    btn[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_write(A_EVT, 32'h2, 4'h1);
    bus_read(A_EVT, rd);  check_vec("t5_set_wins", rd, 32'h2);
    check_vec("t5_irq_masked", {31'd0, btn_irq}, 32'h0);
    btn[1] = 1'b0; repeat (14) @(negedge clk);
    bus_write(A_EVT, 32'h2, 4'h1);
    bus_read(A_EVT, rd);  check_vec("t5_evt1_cleared", rd, 32'h0);

    // 6: writes to RO/unmapped addresses and wen==0 change nothing
    bus_write(A_SW, 32'hffffffff, 4'hf);
    bus_write(A_HOLE, 32'hffffffff, 4'hf);
    bus_write(A_IMASK, 32'hffffffff, 4'h0);
    bus_read(A_IMASK, rd); check_vec("t6_imask_kept", rd, 32'h4);
    bus_read(A_HOLE, rd);  check_vec("t6_hole_reads_0", rd, 32'h0);
    bus_read(A_BTN, rd);   check_vec("t6_btn_kept", rd, 32'h0);
    bus_read(A_SW, rd);    check_vec("t6_sw_kept", rd, 32'h0000a5a5);
    repeat (3) @(negedge clk);
    check_vec("t6_rdata_holds", u_if.conf_rdata, 32'h0000a5a5);

    // 7: button held through reset gives no event until released and pressed again
    btn[1] = 1'b1;
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    check_vec("t7_rdata_reset", u_if.conf_rdata, 32'h0);
    bus_read(A_IMASK, rd); check_vec("t7_imask_reset", rd, 32'h0);
    check_vec("t7_irq_reset", {31'd0, btn_irq}, 32'h0);
    repeat (30) @(negedge clk);
    bus_read(A_BTN, rd);  check_vec("t7_btn_held", rd, 32'h2);
    bus_read(A_EVT, rd);  check_vec("t7_no_evt_held", rd, 32'h0);
    btn[1] = 1'b0; repeat (16) @(negedge clk);
    btn[1] = 1'b1; repeat (16) @(negedge clk);
    bus_read(A_EVT, rd);  check_vec("t7_evt_after_repress", rd, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
